xgen_sched: RTL

- Sequences one batch of per-link joint sin/cos values through the shared, bank-muxed transform generator (xgen1..xgenN selected by link index).
- Latches all NUM_LINKS sin/cos pairs on start, then issues one link per cycle to the generator bank.
- Tracks the bank's fixed latency and presents each link's transform-valid strobe, with link id, to the downstream consumer (RNEA forward pass).
- Downstream backpressure freezes issue and the in-flight tracking together.

---
 rtl/xgen_sched_pkg.sv | 14 +
 rtl/xgen_lat_track.sv | 55 +++++
 rtl/xgen_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/xgen_sched_pkg.sv
// Shared types and constants for the transform-generator batch scheduler.
package xgen_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned LINK_W       = 3;
    localparam int unsigned MAX_XGEN_LAT = 4;

endpackage

// File: rtl/xgen_lat_track.sv
// Enable-gated {valid, link} delay line mirroring the generator bank latency.
module xgen_lat_track
    import xgen_sched_pkg::*;
#(
    parameter int unsigned XGEN_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_in,
    input  logic              valid_in,
    input  logic [LINK_W-1:0] link_in,
    output logic              valid_out,
    output logic [LINK_W-1:0] link_out,
    output logic              empty_out,
    output logic              last_out
);

    localparam logic [XGEN_LAT-1:0] TAIL_ONLY = XGEN_LAT'(1) << (XGEN_LAT - 1);

    logic [XGEN_LAT-1:0] valid_q, valid_d;
    logic [LINK_W-1:0]   link_q [XGEN_LAT];
    logic [LINK_W-1:0]   link_d [XGEN_LAT];

    always_comb begin
        valid_d = valid_q;
        link_d  = link_q;
        if (en_in) begin
            valid_d[0] = valid_in;
            link_d[0]  = link_in;
            for (int unsigned i = 1; i < XGEN_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                link_d[i]  = link_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < XGEN_LAT; i++) begin
                link_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            link_q  <= link_d;
        end
    end

    assign valid_out = valid_q[XGEN_LAT-1];
    assign link_out  = link_q[XGEN_LAT-1];
    assign empty_out = ~|valid_q;
    // Only the tail is occupied: one more enabled edge empties the line.
    assign last_out  = (valid_q == TAIL_ONLY);

endmodule

// File: rtl/xgen_sched.sv
// Batch scheduler: latches per-link sin/cos, issues one link per cycle to the
// shared generator bank and tracks the bank latency to flag each transform.
module xgen_sched
    import xgen_sched_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DECIMAL_BITS = 16,
    parameter int unsigned NUM_LINKS    = 7,
    parameter int unsigned XGEN_LAT     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start_in,
    output logic                       ready_out,
    input  logic [NUM_LINKS*WIDTH-1:0] sinq_in,
    input  logic [NUM_LINKS*WIDTH-1:0] cosq_in,
    output logic                       issue_valid_out,
    output logic [LINK_W-1:0]          link_sel_out,
    output logic [WIDTH-1:0]           sinq_out,
    output logic [WIDTH-1:0]           cosq_out,
    input  logic                       xform_ready_in,
    output logic                       xform_valid_out,
    output logic [LINK_W-1:0]          xform_link_out,
    output logic                       bank_en_out,
    output logic                       done_out
);

    localparam bit CFG_OK = (NUM_LINKS >= 1) && (NUM_LINKS <= 8) &&
                            (XGEN_LAT >= 1) && (XGEN_LAT <= MAX_XGEN_LAT) &&
                            (DECIMAL_BITS < WIDTH);
    localparam logic [LINK_W-1:0] LAST_LINK = LINK_W'(NUM_LINKS - 1);

    state_e              state_q, state_d;
    logic [LINK_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]    sin_rf_q [NUM_LINKS];
    logic [WIDTH-1:0]    sin_rf_d [NUM_LINKS];
    logic [WIDTH-1:0]    cos_rf_q [NUM_LINKS];
    logic [WIDTH-1:0]    cos_rf_d [NUM_LINKS];
    logic                issue_valid_q, issue_valid_d;
    logic [LINK_W-1:0]   link_sel_q, link_sel_d;
    logic [WIDTH-1:0]    sinq_q, sinq_d;
    logic [WIDTH-1:0]    cosq_q, cosq_d;
    logic                trk_empty, trk_last;

    cfg_legal_a: assert property (@(posedge clk) CFG_OK);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sin_rf_d      = sin_rf_q;
        cos_rf_d      = cos_rf_q;
        issue_valid_d = issue_valid_q;
        link_sel_d    = link_sel_q;
        sinq_d        = sinq_q;
        cosq_d        = cosq_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    for (int unsigned k = 0; k < NUM_LINKS; k++) begin
                        sin_rf_d[k] = sinq_in[k*WIDTH +: WIDTH];
                        cos_rf_d[k] = cosq_in[k*WIDTH +: WIDTH];
                    end
                    ptr_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xform_ready_in) begin
                    issue_valid_d = 1'b1;
                    link_sel_d    = ptr_q;
                    sinq_d        = sin_rf_q[ptr_q];
                    cosq_d        = cos_rf_q[ptr_q];
                    ptr_d         = ptr_q + 1'b1;
                    if (ptr_q == LAST_LINK) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xform_ready_in) begin
                    issue_valid_d = 1'b0;
                end
                // Last issue has entered the line; leave once the tail is accepted.
                if (!issue_valid_q && (trk_empty || (trk_last && xform_ready_in))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            link_sel_q    <= '0;
            sinq_q        <= '0;
            cosq_q        <= '0;
            for (int unsigned k = 0; k < NUM_LINKS; k++) begin
                sin_rf_q[k] <= '0;
                cos_rf_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            link_sel_q    <= link_sel_d;
            sinq_q        <= sinq_d;
            cosq_q        <= cosq_d;
            sin_rf_q      <= sin_rf_d;
            cos_rf_q      <= cos_rf_d;
        end
    end

    xgen_lat_track #(
        .XGEN_LAT (XGEN_LAT)
    ) u_lat_track (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_in     (xform_ready_in),
        .valid_in  (issue_valid_q),
        .link_in   (link_sel_q),
        .valid_out (xform_valid_out),
        .link_out  (xform_link_out),
        .empty_out (trk_empty),
        .last_out  (trk_last)
    );

    assign ready_out       = (state_q == ST_IDLE);
    assign done_out        = (state_q == ST_DONE);
    assign issue_valid_out = issue_valid_q;
    assign link_sel_out    = link_sel_q;
    assign sinq_out        = sinq_q;
    assign cosq_out        = cosq_q;
    assign bank_en_out     = xform_ready_in;

endmodule
